// File: rtl/pick_motion_ctrl_if.sv
// Bundle between the active lock-picking level and the pick motion controller.
// The level side (master) drives frame timing, keys and solve status; the controller (slave) returns pick state.
interface pick_motion_ctrl_if;
  logic       frame_tick;
  logic       enable;
  logic [7:0] keycode;
  logic       levelDone;
  logic [9:0] pickY;
  logic [9:0] pickLRx;
  logic       openner;
  logic       busy;
  logic       solved;

  modport master (
    output frame_tick, enable, keycode, levelDone,
    input  pickY, pickLRx, openner, busy, solved
  );

  modport slave (
    input  frame_tick, enable, keycode, levelDone,
    output pickY, pickLRx, openner, busy, solved
  );
endinterface

// File: rtl/pick_motion_ctrl.sv
// Keyboard-driven pick motion controller: per-frame vertical travel, then advance/probe/retract.
// All outputs are registered; motion is applied only on frame_tick cycles.
module pick_motion_ctrl #(
  parameter int unsigned Y_MIN       = 32,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned Y_HOME      = 256,
  parameter int unsigned Y_STEP      = 2,
  parameter int unsigned X_HOME      = 560,
  parameter int unsigned X_PROBE     = 500,
  parameter int unsigned X_STEP      = 4,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input logic               Clk,
  input logic               reset,
  pick_motion_ctrl_if.slave bus
);

  localparam int unsigned CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAVEL,
    S_ADVANCE,
    S_PROBE,
    S_RETRACT,
    S_SOLVED
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    y_q, y_d;
  logic [9:0]    x_q, x_d;
  logic          open_q, open_d;
  logic          busy_q, busy_d;
  logic          solved_q, solved_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [9:0] y_up, y_dn, x_adv, x_ret;

  // Saturating steps evaluated in 11 bits so neither end can wrap.
  always_comb begin
    y_up  = ({1'b0, y_q} < 11'(Y_MIN + Y_STEP)) ? 10'(Y_MIN)
                                                : 10'({1'b0, y_q} - 11'(Y_STEP));
    y_dn  = (({1'b0, y_q} + 11'(Y_STEP)) > 11'(Y_MAX)) ? 10'(Y_MAX)
                                                       : 10'({1'b0, y_q} + 11'(Y_STEP));
    x_adv = ({1'b0, x_q} < 11'(X_PROBE + X_STEP)) ? 10'(X_PROBE)
                                                  : 10'({1'b0, x_q} - 11'(X_STEP));
    x_ret = (({1'b0, x_q} + 11'(X_STEP)) > 11'(X_HOME)) ? 10'(X_HOME)
                                                        : 10'({1'b0, x_q} + 11'(X_STEP));
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    x_d     = x_q;
    open_d  = open_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;

    if (bus.frame_tick && (bus.keycode != KEY_SPACE)) begin
      armed_d = 1'b1;
    end

    if (!bus.enable) begin
      state_d = S_IDLE;
      y_d     = 10'(Y_HOME);
      x_d     = 10'(X_HOME);
      open_d  = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_TRAVEL;
        end
        S_TRAVEL: begin
          if (bus.frame_tick) begin
            if (bus.keycode == KEY_W) begin
              y_d = y_up;
            end else if (bus.keycode == KEY_S) begin
              y_d = y_dn;
            end else if ((bus.keycode == KEY_SPACE) && armed_q) begin
              state_d = S_ADVANCE;
              armed_d = 1'b0;
            end
          end
        end
        S_ADVANCE: begin
          if (bus.frame_tick) begin
            x_d = x_adv;
            if (x_adv == 10'(X_PROBE)) begin
              state_d = S_PROBE;
              open_d  = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        S_PROBE: begin
          // A solve seen on any probe cycle beats the hold-counter expiry.
          if (bus.levelDone) begin
            state_d = S_SOLVED;
          end else if (bus.frame_tick) begin
            if (cnt_q == CW'(HOLD_FRAMES - 1)) begin
              state_d = S_RETRACT;
              open_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_RETRACT: begin
          if (bus.frame_tick) begin
            x_d = x_ret;
            if (x_ret == 10'(X_HOME)) begin
              state_d = S_TRAVEL;
            end
          end
        end
        S_SOLVED: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d   = (state_d == S_ADVANCE) || (state_d == S_PROBE) || (state_d == S_RETRACT);
    solved_d = (state_d == S_SOLVED);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      y_q      <= 10'(Y_HOME);
      x_q      <= 10'(X_HOME);
      open_q   <= 1'b1;
      busy_q   <= 1'b0;
      solved_q <= 1'b0;
      armed_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      x_q      <= x_d;
      open_q   <= open_d;
      busy_q   <= busy_d;
      solved_q <= solved_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.pickY   = y_q;
  assign bus.pickLRx = x_q;
  assign bus.openner = open_q;
  assign bus.busy    = busy_q;
  assign bus.solved  = solved_q;

endmodule

// File: tb/tb_pick_motion_ctrl.sv
// Self-checking bench for pick_motion_ctrl: travel vector table plus hand-written probe, solve,
// enable-drop and reset sequences, all checked through an expected-value queue.
module tb_pick_motion_ctrl;

  localparam logic [7:0] K_W     = 8'h1A;
  localparam logic [7:0] K_S     = 8'h16;
  localparam logic [7:0] K_SPACE = 8'h2C;
  localparam logic [7:0] K_NONE  = 8'h00;
  localparam logic [7:0] K_OTHER = 8'h04;

  logic clk;
  logic rst;

  pick_motion_ctrl_if bus();

  pick_motion_ctrl #(
    .Y_MIN(32), .Y_MAX(479), .Y_HOME(256), .Y_STEP(2),
    .X_HOME(560), .X_PROBE(500), .X_STEP(4), .HOLD_FRAMES(8)
  ) dut (
    .Clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] y;
    logic [9:0] x;
    logic       op;
    logic       busy;
    logic       solved;
  } exp_t;

  typedef struct {
    logic       tick;
    logic [7:0] key;
    logic [9:0] ey;
    string      nm;
  } vec_t;

  exp_t  sb[$];
  string sb_nm[$];
  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  e;
  string enm;

  // Monitor: compares the entry queued for the edge that just happened.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      enm = sb_nm.pop_front();
      n_checks++;
      if (bus.pickY !== e.y || bus.pickLRx !== e.x || bus.openner !== e.op ||
          bus.busy !== e.busy || bus.solved !== e.solved) begin
        n_fail++;
        $display("FAIL %s @%0t: got y=%0d x=%0d op=%b busy=%b solved=%b, want y=%0d x=%0d op=%b busy=%b solved=%b",
                 enm, $time, bus.pickY, bus.pickLRx, bus.openner, bus.busy, bus.solved,
                 e.y, e.x, e.op, e.busy, e.solved);
      end
    end
  end

  task automatic cyc(input logic tk, input logic [7:0] kc, input string nm,
                     input logic [9:0] ey, input logic [9:0] ex,
                     input logic eo, input logic eb, input logic es);
    exp_t t;
    bus.frame_tick = tk;
    bus.keycode    = kc;
    t.y = ey; t.x = ex; t.op = eo; t.busy = eb; t.solved = es;
    sb.push_back(t);
    sb_nm.push_back(nm);
    @(posedge clk);
    #2;
    bus.frame_tick = 1'b0;
  endtask

  function automatic void addv(input logic tk, input logic [7:0] kc, input int ey, input string nm);
    vec_t v;
    v.tick = tk; v.key = kc; v.ey = 10'(ey); v.nm = nm;
    vecs.push_back(v);
  endfunction

  // Full advance / hold / retract cycle from TRAVEL at height y with Space held throughout.
  task automatic full_probe(input logic [9:0] y);
    cyc(1'b1, K_SPACE, "probe_start", y, 10'd560, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, K_SPACE, "advance", y, 10'(560 - 4 * i), (i != 15), 1'b1, 1'b0);
      if (i == 7) cyc(1'b0, K_SPACE, "advance_gap", y, 10'd532, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, K_SPACE, "probe_hold", y, 10'd500, (i == 8), 1'b1, 1'b0);
      if (i == 3) cyc(1'b0, K_SPACE, "probe_gap", y, 10'd500, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 1; i <= 15; i++)
      cyc(1'b1, K_SPACE, "retract", y, 10'(500 + 4 * i), 1'b1, (i != 15), 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, K_SPACE, "space_held_no_reprobe", y, 10'd560, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Travel vector table: expected pickY after each applied cycle.
    for (int i = 1; i <= 10; i++) addv(1'b1, K_W, 256 - 2 * i, "w_step");
    addv(1'b0, K_W,     236, "w_no_tick");
    addv(1'b1, K_OTHER, 236, "other_key");
    addv(1'b1, K_NONE,  236, "no_key");
    for (int i = 1; i <= 101; i++) addv(1'b1, K_W, 236 - 2 * i, "w_to_34");
    for (int i = 0; i < 3; i++) addv(1'b1, K_W, 32, "w_clamp_top");
    for (int i = 1; i <= 223; i++) addv(1'b1, K_S, 32 + 2 * i, "s_to_478");
    addv(1'b1, K_S, 479, "s_clamp_bottom");
    addv(1'b1, K_S, 479, "s_hold_bottom");
    addv(1'b1, K_W, 477, "w_from_bottom");

    rst = 1'b1;
    bus.enable     = 1'b0;
    bus.frame_tick = 1'b0;
    bus.keycode    = K_NONE;
    bus.levelDone  = 1'b0;
    cyc(1'b0, K_NONE, "reset", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, K_W, "idle_disabled", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);
    bus.enable = 1'b1;
    cyc(1'b0, K_NONE, "enable_travel", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i])
      cyc(vecs[i].tick, vecs[i].key, vecs[i].nm, vecs[i].ey, 10'd560, 1'b1, 1'b0, 1'b0);

    full_probe(10'd477);
    cyc(1'b1, K_NONE, "rearm", 10'd477, 10'd560, 1'b1, 1'b0, 1'b0);

    // Solve during probe; levelDone outside PROBE must be ignored.
    cyc(1'b1, K_SPACE, "solve_adv_start", 10'd477, 10'd560, 1'b1, 1'b1, 1'b0);
    bus.levelDone = 1'b1;
    cyc(1'b1, K_NONE, "done_ignored_adv", 10'd477, 10'd556, 1'b1, 1'b1, 1'b0);
    bus.levelDone = 1'b0;
    for (int i = 2; i <= 15; i++)
      cyc(1'b1, K_NONE, "solve_adv", 10'd477, 10'(560 - 4 * i), (i != 15), 1'b1, 1'b0);
    cyc(1'b1, K_NONE, "probe_t1", 10'd477, 10'd500, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, K_NONE, "probe_t2", 10'd477, 10'd500, 1'b0, 1'b1, 1'b0);
    bus.levelDone = 1'b1;
    cyc(1'b1, K_NONE, "solved_entry", 10'd477, 10'd500, 1'b0, 1'b0, 1'b1);
    bus.levelDone = 1'b0;
    cyc(1'b1, K_W, "solved_frozen", 10'd477, 10'd500, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, K_S, "solved_frozen", 10'd477, 10'd500, 1'b0, 1'b0, 1'b1);
    bus.enable = 1'b0;
    cyc(1'b0, K_NONE, "solved_to_idle", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);

    // Enable dropped mid-advance on a tick cycle.
    bus.enable = 1'b1;
    cyc(1'b0, K_NONE, "re_enable", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, K_W, "w_before_drop", 10'd254, 10'd560, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, K_SPACE, "drop_adv_start", 10'd254, 10'd560, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++)
      cyc(1'b1, K_SPACE, "drop_adv", 10'd254, 10'(560 - 4 * i), 1'b1, 1'b1, 1'b0);
    bus.enable = 1'b0;
    cyc(1'b1, K_SPACE, "enable_drop", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);

    // Reset in PROBE coincident with a tick, then a fresh probe must hold the full 8 frames.
    bus.enable = 1'b1;
    cyc(1'b0, K_NONE, "re_enable2", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, K_NONE, "rearm2", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, K_SPACE, "rst_adv_start", 10'd256, 10'd560, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++)
      cyc(1'b1, K_NONE, "rst_adv", 10'd256, 10'(560 - 4 * i), (i != 15), 1'b1, 1'b0);
    cyc(1'b1, K_NONE, "rst_probe_t1", 10'd256, 10'd500, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, K_NONE, "rst_probe_t2", 10'd256, 10'd500, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, K_SPACE, "reset_in_probe", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, K_NONE, "after_reset_travel", 10'd256, 10'd560, 1'b1, 1'b0, 1'b0);
    full_probe(10'd256);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
